clk_div_sched: RTL and testbench

Programmable clock-enable scheduler that replaces free-running ripple dividers with a single synchronous counter in the `clk` domain. It produces a one-cycle `tick` enable and a 50%-duty `div_out` at a selectable ratio of 2^sel. Ratio changes go through a request/acknowledge handshake and take effect only at a period boundary, so downstream logic never sees a runt or stretched period. It sits between the top-level clock/reset and any logic that previously hung off `clk_div2`…`clk_div16`.

---
 rtl/clk_div_sched.sv | 127 ++++++++++++
 tb/tb_clk_div_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
// Single-counter clock-enable scheduler: tick/div_out at 2^cur_sel, ratio changes land only on period boundaries.
// Outputs decode registers only; ack is 1 cycle from IDLE/boundary requests, else at term; requests while busy are dropped.
module clk_div_sched #(
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       cfg_req,
    input  logic [2:0] cfg_sel,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic       busy,
    output logic [2:0] cur_sel,
    output logic       tick,
    output logic       div_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cur_sel_q, cur_sel_d;
    logic [2:0]       pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic [CNT_W:0]   period;
    logic [CNT_W-1:0] term;
    logic [CNT_W-1:0] cnt_sh;
    logic             at_term;
    logic             active;
    logic             sel_legal;
    logic             req_take;

    // period is one bit wider so sel==CNT_W still yields an all-ones terminal count
    assign period    = {{CNT_W{1'b0}}, 1'b1} << cur_sel_q;
    assign term      = period[CNT_W-1:0] - CNT_W'(1);
    assign at_term   = (cnt_q == term);
    assign active    = (state_q != IDLE);
    assign cnt_sh    = cnt_q >> (cur_sel_q - 3'd1);
    assign sel_legal = (cfg_sel != 3'd0) && (int'({29'd0, cfg_sel}) <= CNT_W);
    assign req_take  = cfg_req && (state_q != PEND);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        pend_d    = pend_q;
        ack_d     = 1'b0;
        err_d     = req_take && !sel_legal;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_take && sel_legal) begin
                    cur_sel_d = cfg_sel;
                    ack_d     = 1'b1;
                end
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (at_term) begin
                    cnt_d = '0;
                    if (req_take && sel_legal) begin
                        cur_sel_d = cfg_sel;
                        ack_d     = 1'b1;
                    end
                    state_d = en ? RUN : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (req_take && sel_legal) begin
                        pend_d  = cfg_sel;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (at_term) begin
                    // old ratio finishes its period before the switch
                    cnt_d     = '0;
                    cur_sel_d = pend_q;
                    ack_d     = 1'b1;
                    state_d   = en ? RUN : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_sel_q <= 3'd1;
            pend_q    <= 3'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign cfg_ack = ack_q;
    assign cfg_err = err_q;
    assign busy    = (state_q == PEND);
    assign cur_sel = cur_sel_q;
    assign tick    = active && at_term;
    assign div_out = active && cnt_sh[0];

endmodule

// File: tb/tb_clk_div_sched.sv
// Randomised plus directed stimulus against a phase/period reference model, checked by a per-cycle scoreboard.
module tb_clk_div_sched;

    localparam int CNT_W = 4;

    logic       clk;
    logic       reset;
    logic       en;
    logic       cfg_req;
    logic [2:0] cfg_sel;
    logic       cfg_ack;
    logic       cfg_err;
    logic       busy;
    logic [2:0] cur_sel;
    logic       tick;
    logic       div_out;

    clk_div_sched #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .cfg_req (cfg_req),
        .cfg_sel (cfg_sel),
        .cfg_ack (cfg_ack),
        .cfg_err (cfg_err),
        .busy    (busy),
        .cur_sel (cur_sel),
        .tick    (tick),
        .div_out (div_out)
    );

    typedef struct packed {
        logic       tick;
        logic       div_out;
        logic       busy;
        logic       ack;
        logic       err;
        logic [2:0] cur;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // reference model: running flag, phase within the period, exponent in force, pending exponent (0 = none)
    bit m_active;
    int m_phase;
    int m_cur;
    int m_pend;
    bit m_ack;
    bit m_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model(input bit r, input bit e, input bit q, input logic [2:0] s);
        bit last;
        if (!r) begin
            m_active = 0; m_phase = 0; m_cur = 1; m_pend = 0; m_ack = 0; m_err = 0;
        end else begin
            last  = m_active && (m_phase == (1 << m_cur) - 1);
            m_ack = 0;
            m_err = 0;
            if (q && m_pend == 0) begin
                if (s == 0 || int'(s) > CNT_W) m_err = 1;
                else if (!m_active || last) begin m_cur = int'(s); m_ack = 1; end
                else m_pend = int'(s);
            end
            if (!m_active) begin
                m_active = e;
                m_phase  = 0;
            end else if (last) begin
                m_phase = 0;
                if (m_pend != 0) begin
                    m_cur  = m_pend;
                    m_pend = 0;
                    m_ack  = 1;
                end
                m_active = e;
            end else begin
                m_phase = m_phase + 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit q, input logic [2:0] s);
        obs_t o;
        reset   = r;
        en      = e;
        cfg_req = q;
        cfg_sel = s;
        model(r, e, q, s);
        o.tick    = m_active && (m_phase == (1 << m_cur) - 1);
        o.div_out = m_active && (m_phase >= (1 << m_cur) / 2);
        o.busy    = (m_pend != 0);
        o.ack     = m_ack;
        o.err     = m_err;
        o.cur     = 3'(m_cur);
        exp_q.push_back(o);
        @(posedge clk);
        #1;
    endtask

    // steer the model (and so the DUT) to a given phase while running
    task automatic wait_phase(input int p);
        for (int i = 0; i < 40 && !(m_active && m_phase == p); i++) step(1, 1, 0, 3'd0);
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        cycle++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{tick, div_out, busy, cfg_ack, cfg_err, cur_sel};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got tick=%b div=%b busy=%b ack=%b err=%b cur=%0d exp tick=%b div=%b busy=%b ack=%b err=%b cur=%0d",
                         cycle, a.tick, a.div_out, a.busy, a.ack, a.err, a.cur,
                         e.tick, e.div_out, e.busy, e.ack, e.err, e.cur);
            end
        end
    end

    initial begin
        reset = 1'b0; en = 1'b0; cfg_req = 1'b0; cfg_sel = 3'd0;
        m_active = 0; m_phase = 0; m_cur = 1; m_pend = 0; m_ack = 0; m_err = 0;

        // reset and default divide-by-2
        repeat (3) step(0, 0, 0, 3'd0);
        repeat (8) step(1, 1, 0, 3'd0);
        repeat (4) step(1, 0, 0, 3'd0);

        // config in IDLE, then run at 16
        step(1, 0, 1, 3'd4);
        repeat (3) step(1, 0, 0, 3'd0);
        repeat (34) step(1, 1, 0, 3'd0);

        // mid-period change 3 -> 2
        repeat (18) step(1, 0, 0, 3'd0);
        step(1, 1, 1, 3'd3);
        wait_phase(2);
        step(1, 1, 1, 3'd2);
        repeat (16) step(1, 1, 0, 3'd0);

        // request coincident with boundary, then requests while busy
        wait_phase(3);
        step(1, 1, 1, 3'd1);
        repeat (4) step(1, 1, 0, 3'd0);
        wait_phase(0);
        step(1, 1, 1, 3'd3);
        step(1, 1, 1, 3'd2);
        step(1, 1, 1, 3'd0);
        repeat (10) step(1, 1, 0, 3'd0);

        // illegal selects
        step(1, 1, 1, 3'd0);
        step(1, 1, 1, 3'd5);
        step(1, 1, 1, 3'd7);
        repeat (3) step(1, 1, 0, 3'd0);

        // drain at sel=3 after en drops at cnt=1
        wait_phase(1);
        repeat (12) step(1, 0, 0, 3'd0);

        // reset while a request is pending
        step(1, 1, 0, 3'd0);
        wait_phase(1);
        step(1, 1, 1, 3'd2);
        step(1, 1, 0, 3'd0);
        step(0, 1, 0, 3'd0);
        repeat (10) step(1, 1, 0, 3'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 19) > 2,
                 $urandom_range(0, 7) == 0,
                 3'($urandom_range(0, 7)));
        end

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
